rat_pc_sequencer: RTL

Control sequencer for the RAT CPU program counter and its input mux. It steps the PC through reset, fetch, execute and interrupt phases, and decides when the PC increments or loads. On a load it also selects the load source: immediate, stack, or interrupt vector. It drives the PC/PC-mux pair, stack-pointer control and scratch-RAM push strobes, and it owns the interrupt-enable flag.

---
 rtl/rat_pc_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/rat_pc_sequencer.sv
// rat_pc_sequencer: program-counter control FSM for the RAT CPU.
// Steps INIT -> FETCH -> EXEC (-> INTERRUPT) and produces the PC, PC-mux,
// stack-pointer, scratch-push and shadow-flag strobes. Owns the interrupt
// enable flag. Only the state and I_FLAG are registered; every strobe is
// decoded combinationally from the current state and the inputs.
module rat_pc_sequencer (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] BR_OP,
  input  logic [1:0] BR_COND,
  input  logic       C_FLAG,
  input  logic       Z_FLAG,
  input  logic       INTR,
  output logic       PC_RST,
  output logic       PC_INC,
  output logic       PC_LD,
  output logic [1:0] PC_MUX_SEL,
  output logic       SP_INCR,
  output logic       SP_DECR,
  output logic       SCR_WE,
  output logic       SCR_DATA_SEL,
  output logic       FLG_SHAD_LD,
  output logic       FLG_SHAD_RESTORE,
  output logic       I_FLAG,
  output logic [1:0] STATE
);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_INTR  = 2'd3;

  localparam logic [2:0] OP_NONE   = 3'd0;
  localparam logic [2:0] OP_JMP    = 3'd1;
  localparam logic [2:0] OP_BRANCH = 3'd2;
  localparam logic [2:0] OP_CALL   = 3'd3;
  localparam logic [2:0] OP_RET    = 3'd4;
  localparam logic [2:0] OP_RETI   = 3'd5;
  localparam logic [2:0] OP_SEI    = 3'd6;
  localparam logic [2:0] OP_CLI    = 3'd7;

  localparam logic [1:0] SEL_IMMED  = 2'd0;
  localparam logic [1:0] SEL_STACK  = 2'd1;
  localparam logic [1:0] SEL_VECTOR = 2'd2;

  logic [1:0] state_q, state_d;
  logic       i_flag_q, i_flag_d;

  // Evaluate a BRANCH condition code against the current ALU flags.
  function automatic logic cond_met(input logic [1:0] cond, input logic c, input logic z);
    logic r;
    case (cond)
      2'd0:    r = c;
      2'd1:    r = ~c;
      2'd2:    r = z;
      2'd3:    r = ~z;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Next-state, interrupt-enable and strobe decode; reset overrides everything.
  always_comb begin
    state_d          = state_q;
    i_flag_d         = i_flag_q;
    PC_RST           = 1'b0;
    PC_INC           = 1'b0;
    PC_LD            = 1'b0;
    PC_MUX_SEL       = SEL_IMMED;
    SP_INCR          = 1'b0;
    SP_DECR          = 1'b0;
    SCR_WE           = 1'b0;
    SCR_DATA_SEL     = 1'b0;
    FLG_SHAD_LD      = 1'b0;
    FLG_SHAD_RESTORE = 1'b0;

    if (RST) begin
      // Suppresses any push or load of the current state in this same cycle.
      PC_RST   = 1'b1;
      state_d  = ST_INIT;
      i_flag_d = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          PC_RST   = 1'b1;
          i_flag_d = 1'b0;
          state_d  = ST_FETCH;
        end
        ST_FETCH: begin
          PC_INC  = 1'b1;
          state_d = ST_EXEC;
        end
        ST_EXEC: begin
          case (BR_OP)
            OP_NONE: begin
              PC_LD = 1'b0;
            end
            OP_JMP: begin
              PC_LD = 1'b1;
            end
            OP_BRANCH: begin
              if (cond_met(BR_COND, C_FLAG, Z_FLAG)) begin
                PC_LD = 1'b1;
              end else begin
                PC_LD = 1'b0;
              end
            end
            OP_CALL: begin
              PC_LD        = 1'b1;
              SCR_WE       = 1'b1;
              SCR_DATA_SEL = 1'b1;
              SP_DECR      = 1'b1;
            end
            OP_RET: begin
              PC_LD      = 1'b1;
              PC_MUX_SEL = SEL_STACK;
              SP_INCR    = 1'b1;
            end
            OP_RETI: begin
              PC_LD            = 1'b1;
              PC_MUX_SEL       = SEL_STACK;
              SP_INCR          = 1'b1;
              FLG_SHAD_RESTORE = 1'b1;
              i_flag_d         = 1'b1;
            end
            OP_SEI: begin
              i_flag_d = 1'b1;
            end
            OP_CLI: begin
              i_flag_d = 1'b0;
            end
            default: begin
              PC_LD = 1'b0;
            end
          endcase
          // Gate on the enable as it stood entering this EXEC, so SEI/RETI
          // take effect at the next boundary and CLI does not cancel a pending one.
          if (INTR && i_flag_q) begin
            state_d = ST_INTR;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_INTR: begin
          PC_LD        = 1'b1;
          PC_MUX_SEL   = SEL_VECTOR;
          SCR_WE       = 1'b1;
          SCR_DATA_SEL = 1'b1;
          SP_DECR      = 1'b1;
          FLG_SHAD_LD  = 1'b1;
          i_flag_d     = 1'b0;
          state_d      = ST_FETCH;
        end
        default: begin
          PC_RST   = 1'b1;
          i_flag_d = 1'b0;
          state_d  = ST_INIT;
        end
      endcase
    end
  end

  // State and interrupt-enable registers.
  always_ff @(posedge CLK) begin
    state_q  <= state_d;
    i_flag_q <= i_flag_d;
  end

  assign I_FLAG = i_flag_q;
  assign STATE  = state_q;

endmodule
